pipe_ctrl: RTL



---
 rtl/y86_pkg.sv | 34 +++
 rtl/pipe_ctrl_if.sv | 35 +++
 rtl/pipe_perf_cnt.sv | 35 +++
 rtl/pipe_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 pipeline constants (icodes, status codes, register
// "none" encoding) and the pipeline-control run-state type.
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Status codes
    localparam logic [1:0] AOK = 2'd0;
    localparam logic [1:0] HLT = 2'd1;
    localparam logic [1:0] ADR = 2'd2;
    localparam logic [1:0] INS = 2'd3;

    // "No register" encoding for source/destination fields
    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STOPPED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: stage-register fields observed by the pipeline control unit
// and the stall/bubble/CC-enable controls it returns to the pipeline.
// slave = control unit side, master = datapath side.
interface pipe_ctrl_if;
    logic [3:0] D_icode;
    logic [3:0] d_srcA;
    logic [3:0] d_srcB;
    logic [3:0] E_icode;
    logic [3:0] E_destM;
    logic       e_Cnd;
    logic [3:0] M_icode;
    logic [1:0] m_status;
    logic [1:0] W_status;
    logic [3:0] W_icode;

    logic       F_stall;
    logic       D_stall;
    logic       D_bubble;
    logic       E_bubble;
    logic       M_bubble;
    logic       W_stall;
    logic       set_cc;

    modport slave (
        input  D_icode, d_srcA, d_srcB, E_icode, E_destM, e_Cnd,
               M_icode, m_status, W_status, W_icode,
        output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
    );

    modport master (
        output D_icode, d_srcA, d_srcB, E_icode, E_destM, e_Cnd,
               M_icode, m_status, W_status, W_icode,
        input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc
    );
endinterface

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: one saturating event counter with synchronous clear.
module pipe_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: Y86-64 pipeline control. Generates stall/bubble/set_cc for the
// F/D/E/M/W registers from load-use, ret and mispredict hazards, and runs an
// IDLE -> RUN -> STOPPED state machine (STOPPED is left only by reset).
// Build option: PIPE_CTRL_PERF_EN adds five saturating performance counters;
// without it the counter ports read as zero and no counter flops exist.
module pipe_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    pipe_ctrl_if.slave       bus,
    output logic             running,
    output logic             halted,
    output logic [1:0]       halt_status,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] mis_cnt,
    output logic [CNT_W-1:0] retd_cnt
);

    ctrl_state_t state_q, state_d;
    logic [1:0]  halt_status_q, halt_status_d;

    logic lu, rt, mp, exc, w_exc;
    logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, set_cc;

    // Hazard detection
    always_comb begin
        lu = ((bus.E_icode == I_MRMOVQ) || (bus.E_icode == I_POPQ)) &&
             (bus.E_destM != REG_NONE) &&
             ((bus.E_destM == bus.d_srcA) || (bus.E_destM == bus.d_srcB));
        rt = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
        mp = (bus.E_icode == I_JXX) && !bus.e_Cnd;
        w_exc = (bus.W_status != AOK);
        exc = (bus.m_status != AOK) || w_exc;
    end

    // Next state and per-state control outputs
    always_comb begin
        state_d       = state_q;
        halt_status_d = halt_status_q;
        f_stall       = 1'b0;
        d_stall       = 1'b0;
        d_bubble      = 1'b0;
        e_bubble      = 1'b0;
        m_bubble      = 1'b0;
        w_stall       = 1'b0;
        set_cc        = 1'b0;
        unique case (state_q)
            IDLE: begin
                f_stall  = 1'b1;
                d_bubble = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                f_stall  = lu | rt;
                d_stall  = lu;
                // A load-use stall holds the ret in D, so no bubble then
                d_bubble = mp | (rt & !lu);
                e_bubble = mp | lu;
                m_bubble = exc;
                w_stall  = w_exc;
                set_cc   = (bus.E_icode == I_OPQ) & !exc;
                if (w_exc) begin
                    halt_status_d = bus.W_status;
                    state_d       = STOPPED;
                end
            end
            STOPPED: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                m_bubble = 1'b1;
                w_stall  = 1'b1;
            end
            default: begin
                // Unreachable encoding: look like IDLE and recover there
                f_stall  = 1'b1;
                d_bubble = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
                state_d  = IDLE;
            end
        endcase
    end

    // Run state and captured halt status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            halt_status_q <= AOK;
        end else begin
            state_q       <= state_d;
            halt_status_q <= halt_status_d;
        end
    end

    assign bus.F_stall  = f_stall;
    assign bus.D_stall  = d_stall;
    assign bus.D_bubble = d_bubble;
    assign bus.E_bubble = e_bubble;
    assign bus.M_bubble = m_bubble;
    assign bus.W_stall  = w_stall;
    assign bus.set_cc   = set_cc;

    assign running     = (state_q == RUN);
    assign halted      = (state_q == STOPPED);
    assign halt_status = halt_status_q;

`ifdef PIPE_CTRL_PERF_EN
    logic cnt_clear;
    logic inc_ret, inc_retd;

    // Counters only move in RUN; IDLE is only reachable through reset, so
    // clearing there keeps them at zero until the next start.
    assign cnt_clear = (state_q == IDLE);
    assign inc_ret   = running & (bus.D_icode == I_RET) & !d_stall;
    assign inc_retd  = running & (bus.W_icode != I_NOP) & (bus.W_status == AOK) & !w_stall;

    pipe_perf_cnt #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clear), .inc(running), .cnt(cyc_cnt)
    );
    pipe_perf_cnt #(.CNT_W(CNT_W)) u_ret_cnt (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clear), .inc(inc_ret), .cnt(ret_cnt)
    );
    pipe_perf_cnt #(.CNT_W(CNT_W)) u_lu_cnt (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clear), .inc(running & lu), .cnt(lu_cnt)
    );
    pipe_perf_cnt #(.CNT_W(CNT_W)) u_mis_cnt (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clear), .inc(running & mp), .cnt(mis_cnt)
    );
    pipe_perf_cnt #(.CNT_W(CNT_W)) u_retd_cnt (
        .clk(clk), .rst_n(rst_n), .clear(cnt_clear), .inc(inc_retd), .cnt(retd_cnt)
    );
`else
    // W_icode only feeds the retired-instruction counter
    logic unused_perf;
    assign unused_perf = ^bus.W_icode;

    assign cyc_cnt  = '0;
    assign ret_cnt  = '0;
    assign lu_cnt   = '0;
    assign mis_cnt  = '0;
    assign retd_cnt = '0;
`endif

endmodule
